// File: rtl/jtag_tap_pkg.sv
// Shared constants for the JTAG TAP: state encodings, instruction opcodes and default device ID.
package jtag_tap_pkg;

  localparam int IR_WIDTH = 4;

  localparam logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'b0001;
  localparam logic [IR_WIDTH-1:0] BYPASS_INSTR = 4'b1111;

  localparam logic [31:0] DEFAULT_IDCODE = 32'hF00ED093;

  // Classic 1149.1 encoding: the low bits mirror between the DR and IR branches.
  localparam logic [3:0] ST_TEST_LOGIC_RESET = 4'hF;
  localparam logic [3:0] ST_RUN_TEST_IDLE    = 4'hC;
  localparam logic [3:0] ST_SELECT_DR_SCAN   = 4'h7;
  localparam logic [3:0] ST_CAPTURE_DR       = 4'h6;
  localparam logic [3:0] ST_SHIFT_DR         = 4'h2;
  localparam logic [3:0] ST_EXIT1_DR         = 4'h1;
  localparam logic [3:0] ST_PAUSE_DR         = 4'h3;
  localparam logic [3:0] ST_EXIT2_DR         = 4'h0;
  localparam logic [3:0] ST_UPDATE_DR        = 4'h5;
  localparam logic [3:0] ST_SELECT_IR_SCAN   = 4'h4;
  localparam logic [3:0] ST_CAPTURE_IR       = 4'hE;
  localparam logic [3:0] ST_SHIFT_IR         = 4'hA;
  localparam logic [3:0] ST_EXIT1_IR         = 4'h9;
  localparam logic [3:0] ST_PAUSE_IR         = 4'hB;
  localparam logic [3:0] ST_EXIT2_IR         = 4'h8;
  localparam logic [3:0] ST_UPDATE_IR        = 4'hD;

endpackage

// File: rtl/jtag_tap_controller.sv
// 16-state TAP controller; state advances on rising TCK from TMS, TRST forces TEST_LOGIC_RESET.
module jtag_tap_controller
  import jtag_tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] state
);

  localparam logic [3:0] TEST_LOGIC_RESET = ST_TEST_LOGIC_RESET;
  localparam logic [3:0] RUN_TEST_IDLE    = ST_RUN_TEST_IDLE;
  localparam logic [3:0] SELECT_DR_SCAN   = ST_SELECT_DR_SCAN;
  localparam logic [3:0] CAPTURE_DR       = ST_CAPTURE_DR;
  localparam logic [3:0] SHIFT_DR         = ST_SHIFT_DR;
  localparam logic [3:0] EXIT1_DR         = ST_EXIT1_DR;
  localparam logic [3:0] PAUSE_DR         = ST_PAUSE_DR;
  localparam logic [3:0] EXIT2_DR         = ST_EXIT2_DR;
  localparam logic [3:0] UPDATE_DR        = ST_UPDATE_DR;
  localparam logic [3:0] SELECT_IR_SCAN   = ST_SELECT_IR_SCAN;
  localparam logic [3:0] CAPTURE_IR       = ST_CAPTURE_IR;
  localparam logic [3:0] SHIFT_IR         = ST_SHIFT_IR;
  localparam logic [3:0] EXIT1_IR         = ST_EXIT1_IR;
  localparam logic [3:0] PAUSE_IR         = ST_PAUSE_IR;
  localparam logic [3:0] EXIT2_IR         = ST_EXIT2_IR;
  localparam logic [3:0] UPDATE_IR        = ST_UPDATE_IR;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      case (state)
        TEST_LOGIC_RESET: state <= TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state <= TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_DR_SCAN:   state <= TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
        CAPTURE_DR:       state <= TMS ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state <= TMS ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state <= TMS ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state <= TMS ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state <= TMS ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state <= TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_IR_SCAN:   state <= TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state <= TMS ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state <= TMS ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state <= TMS ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state <= TMS ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state <= TMS ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state <= TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        default:          state <= TEST_LOGIC_RESET;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP top: instruction, IDCODE and BYPASS registers around the TAP controller; TDO launched on falling TCK.
module jtag_tap
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE = DEFAULT_IDCODE
) (
  input  logic TCK,
  input  logic TRST,
  input  logic TMS,
  input  logic TDI,
  output logic TDO
);

  logic [3:0]          state;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [31:0]         dr_q, dr_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                idcode_sel;

  jtag_tap_controller controller (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (TMS),
    .state (state)
  );

  // Any opcode other than IDCODE falls back to BYPASS.
  assign idcode_sel = (ir_q == IDCODE_INSTR);

  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    dr_d       = dr_q;
    bypass_d   = bypass_q;
    case (state)
      ST_TEST_LOGIC_RESET: ir_d       = IDCODE_INSTR;
      ST_CAPTURE_IR:       ir_shift_d = IDCODE_INSTR;
      ST_SHIFT_IR:         ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
      ST_UPDATE_IR:        ir_d       = ir_shift_q;
      ST_CAPTURE_DR: begin
        if (idcode_sel) dr_d     = IDCODE;
        else            bypass_d = 1'b0;
      end
      ST_SHIFT_DR: begin
        if (idcode_sel) dr_d     = {TDI, dr_q[31:1]};
        else            bypass_d = TDI;
      end
      default: ;
    endcase
  end

  always_comb begin
    tdo_d = 1'b0;
    case (state)
      ST_SHIFT_DR: tdo_d = idcode_sel ? dr_q[0] : bypass_q;
      ST_SHIFT_IR: tdo_d = ir_shift_q[0];
      default:     tdo_d = 1'b0;
    endcase
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift_q <= IDCODE_INSTR;
      ir_q       <= IDCODE_INSTR;
      dr_q       <= IDCODE;
      bypass_q   <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      ir_q       <= ir_d;
      dr_q       <= dr_d;
      bypass_q   <= bypass_d;
    end
  end

  // Falling-edge launch keeps TDO stable across the host's rising-edge sample.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) tdo_q <= 1'b0;
    else      tdo_q <= tdo_d;
  end

  assign TDO = tdo_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: walks the TAP through DR/IR scans and TRST, checking against hand-computed values.
module tb_jtag_tap;

  localparam logic [3:0] S_TLR = 4'hF;
  localparam logic [3:0] S_RTI = 4'hC;
  localparam logic [3:0] S_SDS = 4'h7;
  localparam logic [3:0] S_CDR = 4'h6;
  localparam logic [3:0] S_SDR = 4'h2;
  localparam logic [3:0] S_E1D = 4'h1;
  localparam logic [3:0] S_UDR = 4'h5;
  localparam logic [3:0] S_SIS = 4'h4;
  localparam logic [3:0] S_CIR = 4'hE;
  localparam logic [3:0] S_SIR = 4'hA;
  localparam logic [3:0] S_E1I = 4'h9;
  localparam logic [3:0] S_UIR = 4'hD;

  logic TCK, TRST, TMS, TDI, TDO;
  int   checks = 0;
  int   errors = 0;

  jtag_tap dut (
    .TCK  (TCK),
    .TRST (TRST),
    .TMS  (TMS),
    .TDI  (TDI),
    .TDO  (TDO)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive TMS/TDI after the falling edge, sample TDO just before the rising edge.
  task automatic step(input logic tms, input logic tdi, output logic tdo_s);
    @(negedge TCK);
    TMS = tms;
    TDI = tdi;
    #2 tdo_s = TDO;
    @(posedge TCK);
    #1;
  endtask

  task automatic go(input logic tms);
    logic d;
    step(tms, 1'b0, d);
  endtask

  // Shift n bits LSB first, raising TMS on the last bit to leave the shift state.
  task automatic shift(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      logic b;
      step(i == n - 1, din[i], b);
      dout[i] = b;
    end
  endtask

  task automatic ir_scan(input logic [3:0] code, output logic [63:0] cap);
    go(1'b1); go(1'b1); go(1'b0); go(1'b0);
    shift(4, {60'd0, code}, cap);
    go(1'b1); go(1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    go(1'b1); go(1'b0); go(1'b0);
    shift(n, din, dout);
    go(1'b1); go(1'b0);
  endtask

  logic [63:0] res;
  logic        b;

  initial begin
    TRST = 1'b1;
    TMS  = 1'b1;
    TDI  = 1'b0;
    #12;
    check("reset_state",  {60'd0, dut.controller.state}, {60'd0, S_TLR});
    check("reset_tdo",    {63'd0, TDO},                  64'd0);
    check("reset_instr",  {60'd0, dut.ir_q},             64'h1);
    check("reset_irsh",   {60'd0, dut.ir_shift_q},       64'h1);
    check("reset_dr",     {32'd0, dut.dr_q},             64'hF00ED093);
    check("reset_bypass", {63'd0, dut.bypass_q},         64'd0);
    @(negedge TCK);
    TRST = 1'b0;

    for (int i = 0; i < 5; i++) go(1'b1);
    check("tms5_tlr", {60'd0, dut.controller.state}, {60'd0, S_TLR});
    go(1'b0);
    check("rti", {60'd0, dut.controller.state}, {60'd0, S_RTI});
    go(1'b1);
    check("sds", {60'd0, dut.controller.state}, {60'd0, S_SDS});
    go(1'b0);
    check("cdr", {60'd0, dut.controller.state}, {60'd0, S_CDR});
    go(1'b0);
    check("sdr", {60'd0, dut.controller.state}, {60'd0, S_SDR});

    shift(64, 64'h0000_0000_0000_007F, res);
    check("idcode_out", {32'd0, res[31:0]},  64'hF00ED093);
    check("tdi_return", {32'd0, res[63:32]}, 64'h7F);
    check("e1d", {60'd0, dut.controller.state}, {60'd0, S_E1D});
    go(1'b1);
    check("udr", {60'd0, dut.controller.state}, {60'd0, S_UDR});
    go(1'b0);
    check("rti2", {60'd0, dut.controller.state}, {60'd0, S_RTI});

    go(1'b1); go(1'b1);
    check("sis", {60'd0, dut.controller.state}, {60'd0, S_SIS});
    go(1'b0);
    check("cir", {60'd0, dut.controller.state}, {60'd0, S_CIR});
    go(1'b0);
    check("sir", {60'd0, dut.controller.state}, {60'd0, S_SIR});
    shift(4, 64'hF, res);
    check("ir_capture", res, 64'h1);
    check("e1i", {60'd0, dut.controller.state}, {60'd0, S_E1I});
    go(1'b1);
    check("uir", {60'd0, dut.controller.state}, {60'd0, S_UIR});
    check("instr_before_update", {60'd0, dut.ir_q}, 64'h1);
    go(1'b0);
    check("instr_bypass", {60'd0, dut.ir_q}, 64'hF);

    // Bypass: first bit is the captured 0, then TDI delayed by one.
    dr_scan(8, 64'hB2, res);
    check("bypass_8", res, 64'h64);
    check("instr_kept", {60'd0, dut.ir_q}, 64'hF);

    ir_scan(4'b0101, res);
    check("ir_capture2", res, 64'h1);
    check("instr_0101", {60'd0, dut.ir_q}, 64'h5);
    dr_scan(4, 64'hD, res);
    check("other_is_bypass", res, 64'hA);

    go(1'b1); go(1'b0); go(1'b0);
    step(1'b0, 1'b1, b);
    step(1'b0, 1'b1, b);
    check("mid_sdr", {60'd0, dut.controller.state}, {60'd0, S_SDR});
    #5;
    check("tdo_before_trst", {63'd0, TDO}, 64'd1);
    TRST = 1'b1;
    #1;
    check("trst_state", {60'd0, dut.controller.state}, {60'd0, S_TLR});
    check("trst_tdo",   {63'd0, TDO}, 64'd0);
    check("trst_instr", {60'd0, dut.ir_q}, 64'h1);
    @(negedge TCK);
    TRST = 1'b0;
    go(1'b0);
    dr_scan(32, 64'd0, res);
    check("idcode_after_trst", res, 64'hF00ED093);

    go(1'b1); go(1'b1); go(1'b0); go(1'b0);
    check("sir2", {60'd0, dut.controller.state}, {60'd0, S_SIR});
    for (int i = 0; i < 5; i++) go(1'b1);
    check("tms5_from_sir", {60'd0, dut.controller.state}, {60'd0, S_TLR});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
